// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package serial_add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Legal when the width is at least 2 and the slice width divides it evenly.
  function automatic bit params_legal(input int unsigned width, input int unsigned step);
    return (width >= 2) && (step >= 1) && (step <= width) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result bundle between a requester and the serial adder/subtractor.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sel, a, b, cin,
    input  busy, done, s, cout, ovf, zero
  );

  modport slave (
    input  start, sel, a, b, cin,
    output busy, done, s, cout, ovf, zero
  );

endinterface

// File: rtl/add_sub_slice.sv
// Combinational STEP-bit ripple add/subtract slice; B is inverted per bit when sel=1.
module add_sub_slice #(
  parameter int unsigned STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            sel,
  input  logic            cin,
  output logic [STEP-1:0] s,
  output logic            cout,
  output logic            c_msb
);

  logic [STEP:0] c;
  logic          bx;

  always_comb begin
    c    = '0;
    s    = '0;
    bx   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < int'(STEP); i++) begin
      bx     = b[i] ^ sel;
      s[i]   = a[i] ^ bx ^ c[i];
      c[i+1] = (a[i] & bx) | (a[i] & c[i]) | (bx & c[i]);
    end
  end

  assign cout  = c[STEP];
  assign c_msb = c[STEP-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one STEP-bit slice, LSB chunk first.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input logic            clk,
  input logic            rst,
  serial_add_sub_if.slave bus
);

  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!params_legal(WIDTH, STEP)) begin : g_param_check
    $error("serial_add_sub: illegal WIDTH=%0d / STEP=%0d", WIDTH, STEP);
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_sh_q, r_sh_d;
  logic               sel_q, sel_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [STEP-1:0]    sl_s;
  logic               sl_cout;
  logic               sl_cmsb;
  logic [WIDTH-1:0]   r_next;

  add_sub_slice #(.STEP(STEP)) u_slice (
    .a     (a_sh_q[STEP-1:0]),
    .b     (b_sh_q[STEP-1:0]),
    .sel   (sel_q),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  // New chunk enters from the MSB side so the last chunk lands in the top bits.
  assign r_next = (r_sh_q >> STEP) | (WIDTH'(sl_s) << (WIDTH - STEP));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    sel_d   = sel_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          sel_d   = bus.sel;
          carry_d = bus.cin ^ bus.sel;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> STEP;
        b_sh_d  = b_sh_q >> STEP;
        r_sh_d  = r_next;
        carry_d = sl_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          s_d     = r_next;
          cout_d  = sl_cout;
          ovf_d   = sl_cout ^ sl_cmsb;
          zero_d  = (r_next == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sel_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench: one bit-serial (STEP=1) and one nibble-serial (STEP=4) 8-bit instance.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t q1[$];
  exp_t q4[$];

  serial_add_sub_if #(.WIDTH(8)) if1 ();
  serial_add_sub_if #(.WIDTH(8)) if4 ();

  serial_add_sub #(.WIDTH(8), .STEP(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  serial_add_sub #(.WIDTH(8), .STEP(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit d4, input logic st, input logic sel,
                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    if (d4) begin
      if4.start = st; if4.sel = sel; if4.a = a; if4.b = b; if4.cin = cin;
    end else begin
      if1.start = st; if1.sel = sel; if1.a = a; if1.b = b; if1.cin = cin;
    end
  endtask

  function automatic logic get_busy(input bit d4);
    return d4 ? if4.busy : if1.busy;
  endfunction

  function automatic logic get_done(input bit d4);
    return d4 ? if4.done : if1.done;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if1.done) begin
        if (q1.size() == 0) chk("u1 unexpected done", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("u1 s", 32'(if1.s), 32'(e.s));
          chk("u1 cout", 32'(if1.cout), 32'(e.c));
          chk("u1 ovf", 32'(if1.ovf), 32'(e.o));
          chk("u1 zero", 32'(if1.zero), 32'(e.z));
        end
      end
      if (if4.done) begin
        if (q4.size() == 0) chk("u4 unexpected done", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("u4 s", 32'(if4.s), 32'(e.s));
          chk("u4 cout", 32'(if4.cout), 32'(e.c));
          chk("u4 ovf", 32'(if4.ovf), 32'(e.o));
          chk("u4 zero", 32'(if4.zero), 32'(e.z));
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic do_op(input bit d4, input logic sel, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic ec, input logic eo,
                       input logic ez, input int lat, input int inj, input string tag);
    exp_t e;
    int   k;
    bit   got;
    e = '{s: es, c: ec, o: eo, z: ez};
    drive(d4, 1'b1, sel, a, b, cin);
    if (d4) q4.push_back(e);
    else q1.push_back(e);
    @(posedge clk); #1;
    drive(d4, 1'b0, ~sel, ~a, ~b, ~cin);
    chk({tag, " busy after start"}, 32'(get_busy(d4)), 32'd1);
    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge clk); #1;
      k++;
      drive(d4, (k == inj), ~sel, 8'hAA, 8'h55, cin);
      got = get_done(d4);
    end
    drive(d4, 1'b0, ~sel, 8'hAA, 8'h55, cin);
    chk({tag, " latency"}, 32'(k), 32'(lat));
    chk({tag, " busy at done"}, 32'(get_busy(d4)), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("u1 reset outputs", 32'({if1.busy, if1.done, if1.cout, if1.ovf, if1.zero, if1.s}), 32'd0);
    chk("u4 reset outputs", 32'({if4.busy, if4.done, if4.cout, if4.ovf, if4.zero, if4.s}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bit-serial instance, ops issued back-to-back in each done cycle.
    do_op(1'b0, OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8, 0, "add 7f+01");
    do_op(1'b0, OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8, 0, "sub 05-05");
    do_op(1'b0, OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 8, 0, "sub 03-05");
    do_op(1'b0, OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 8, 0, "sub 80-01");
    do_op(1'b0, OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 8, 0, "sub 10-01-1");
    // Start at edge 3 with other operands must be ignored.
    do_op(1'b0, OP_ADD, 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 8, 2, "add ignore start");

    // Nibble-serial instance, second op accepted in the done cycle.
    do_op(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2, 0, "s4 add ff+01");
    do_op(1'b1, OP_ADD, 8'h50, 8'h30, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 2, 0, "s4 back-to-back");

    // Asynchronous reset four edges into a bit-serial op.
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, OP_ADD, 8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort outputs", 32'({if1.busy, if1.done, if1.cout, if1.ovf, if1.zero, if1.s}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort no busy", 32'(if1.busy), 32'd0);
    do_op(1'b0, OP_ADD, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8, 0, "after reset");

    repeat (5) @(posedge clk);
    #1;
    chk("u1 queue drained", 32'(q1.size()), 32'd0);
    chk("u4 queue drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised multi-cycle N-bit adder/subtractor built around a STEP-bit add/subtract slice that is reused every cycle.
- Operands are loaded on a start handshake and processed LSB-first, STEP bits per cycle.
- Outputs are a registered sum/difference plus carry, signed-overflow and zero flags.
- A done pulse signals completion.
- Serves the datapath labs as the area-lean successor of the single-bit add/sub cell.

Parameters:
- WIDTH, 8, operand/result width in bits; must be at least 2.
- STEP, 1, bits processed per cycle; must divide WIDTH; STEP=WIDTH gives a single-cycle operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only while busy=0
- sel  input  1  0 = add, 1 = subtract
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in when adding, borrow-in when subtracting
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- s  output  WIDTH  result
- cout  output  1  final carry-out; in subtract mode 1 means no borrow
- ovf  output  1  two's-complement overflow
- zero  output  1  result equals 0

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, s=0, cout=0, ovf=0, zero=0; internal counter, shift registers and carry cleared.
- Arithmetic definition:
  - s = a + (b XOR {WIDTH{sel}}) + (cin XOR sel), modulo 2^WIDTH.
  - sel=1, cin=0 computes a-b; sel=1, cin=1 computes a-b-1.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (s == 0).
- FSM has two states, IDLE and RUN. Let N = WIDTH/STEP.
- IDLE, edge with start=1:
  - latch a, b, sel;
  - set running carry = cin XOR sel;
  - clear step counter;
  - busy goes 1; move to RUN.
- RUN, each edge:
  - slice adds the low STEP bits of the A and B shift registers with the running carry;
  - result chunk shifts into the result shift register from the MSB side;
  - A and B shift right by STEP;
  - carry register updates;
  - counter increments.
- On the edge that processes chunk N-1:
  - s, cout, ovf, zero are written from the final values;
  - busy goes 0, done goes 1 for exactly one cycle;
  - state returns to IDLE.
- Latency: start sampled at edge 0, done/results visible after edge N. With STEP=1, WIDTH=8 that is edge 8.
- During RUN, s and the flags hold the previous result. Results hold until the next completion.
- start while busy=1 is ignored and has no effect on the running operation. Changes to a, b, sel or cin during RUN are ignored.
- start=1 in the cycle done=1 is accepted, giving back-to-back operation.
- rst asserted mid-RUN aborts immediately: no done, all outputs return to their reset values.
- ovf is computed from the carry into the top bit, tapped inside the final slice.

Decomposition:
- Shared header: OP_ADD=1'b0, OP_SUB=1'b1; FSM state encodings S_IDLE, S_RUN; parameter legality check (STEP divides WIDTH, WIDTH>=2), which raises a simulation error on violation.
- One sub-module, add_sub_slice (parameter STEP).
- add_sub_slice ports:
  - inputs: a[STEP], b[STEP], sel, cin;
  - outputs: s[STEP], cout, c_msb (carry into the slice MSB).
- add_sub_slice is purely combinational: a ripple of full-adder bits with B XOR sel per bit.
- Instantiated once in serial_add_sub.

Test Plan:
- WIDTH=8, STEP=1; sel=0, a=0x7F, b=0x01, cin=0, start pulse -> busy for 8 cycles, done after edge 8; s=0x80, cout=0, ovf=1, zero=0.
- sel=1, a=0x05, b=0x05, cin=0 -> s=0x00, cout=1, ovf=0, zero=1. Then a=0x03, b=0x05 -> s=0xFE, cout=0, ovf=0.
- sel=1, a=0x80, b=0x01, cin=0 -> s=0x7F, cout=1, ovf=1. Then sel=1, a=0x10, b=0x01, cin=1 -> s=0x0E.
- WIDTH=8, STEP=4; sel=0, a=0xFF, b=0x01, cin=0 -> done after edge 2; s=0x00, cout=1, zero=1, ovf=0.
- Start again at edge 3 mid-RUN with different operands -> ignored, first result unchanged. Start asserted in the done cycle -> second op accepted, its done arrives N edges later.
- rst=1 asynchronously at edge 4 of an 8-cycle op -> outputs 0 immediately, no done pulse. A fresh start after reset release gives the correct result.
